fsm_autos: RTL and testbench
============================

// Module: fsm_autos
// PURPOSE
//  Parking-lot gate direction detector. Two adjacent beam sensors (A outside, B inside) are
//  tracked by a Moore FSM that recognises a complete car passage in either direction.
//  Emits a one-cycle carIn pulse per entry and a carOut pulse per exit; feeds the occupancy counter.
//  Pedestrians, aborted passages and anomalous patterns produce no pulse.
// PARAMETERS
//  none
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  reset     in   1  synchronous, active-high; one clock, sync reset
//  sensor_a  in   1  1 = outer beam blocked; already synchronous/debounced to clk
//  sensor_b  in   1  1 = inner beam blocked; already synchronous/debounced to clk
//  carIn     out  1  registered 1-cycle pulse: car entered
//  carOut    out  1  registered 1-cycle pulse: car left
// BEHAVIOUR
//  - Inputs sampled as AB = {sensor_a,sensor_b} each rising edge; one transition per edge.
//  - States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, FAULT. Reset -> IDLE, carIn=carOut=0.
//  - Reset has priority over all transitions; reset mid-passage aborts it, no pulse.
//  - Any state holds while AB equals its own pattern (IN1/OUT3=10, IN2/OUT2=11, IN3/OUT1=01).
//  - IDLE: 00 stay; 10->IN1; 01->OUT1; 11->FAULT.
//  - IN1 : 11->IN2; 00->IDLE (pedestrian/abort); 01->FAULT.
//  - IN2 : 01->IN3; 10->IN1 (backs out); 00->FAULT.
//  - IN3 : 00->IDLE and carIn=1 next cycle; 11->IN2 (backs up); 10->FAULT.
//  - OUT1: 11->OUT2; 00->IDLE (abort); 10->FAULT.
//  - OUT2: 10->OUT3; 01->OUT1 (backs out); 00->FAULT.
//  - OUT3: 00->IDLE and carOut=1 next cycle; 11->OUT2; 01->FAULT.
//  - FAULT: stay until AB=00, then ->IDLE; never pulses.
//  - Pulse timing: on the edge that samples 00 in IN3 (OUT3) the FSM enters IDLE and the
//    output register loads 1; it is 1 for exactly one clock, cleared the following edge.
//  - carIn and carOut are never high simultaneously; both 0 in every other cycle.
//  - Back-and-forth rocking (IN2<->IN1, IN3<->IN2, etc.) may repeat indefinitely;
//    one pulse only when the full sequence finally completes to 00.
//  - Outputs are flop outputs, no combinational path from sensors.
// TESTING
//  1 reset=1 for 1 cycle, AB=00 -> state IDLE, carIn=carOut=0.
//  2 AB 10,11,01,00 one per clock -> carIn=1 for exactly 1 cycle after 00 sampled; carOut=0.
//  3 AB 01,11,10,00 -> carOut=1 for exactly 1 cycle; carIn=0.
//  4 Pedestrian: AB 10,00 then 01,00 -> no pulses, IDLE.
//  5 Abort mid-entry 10,11,10 (hold) and mid-exit 01,11,01 -> no pulses; subsequent
//    completion (e.g. 11,01,00) yields exactly one carIn.
//  6 Anomaly AB 11 from IDLE, then 00 -> FAULT then IDLE, no pulses; then a valid
//    entry gives one carIn. Also reset asserted while in IN3 -> no carIn.

Source files
------------

// File: rtl/fsm_autos.sv
// Parking-lot gate direction detector: tracks two adjacent beam sensors and
// emits one registered pulse per completed car entry (carIn) or exit (carOut).
module fsm_autos (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic carIn,
    output logic carOut
);

    // state | meaning
    // ------+---------------------------------------------------------------
    // IDLE  | both beams clear, no passage in progress
    // IN1   | entry started: outer beam only (AB=10)
    // IN2   | entry midway: both beams blocked (AB=11)
    // IN3   | entry ending: inner beam only (AB=01); 00 completes the entry
    // OUT1  | exit started: inner beam only (AB=01)
    // OUT2  | exit midway: both beams blocked (AB=11)
    // OUT3  | exit ending: outer beam only (AB=10); 00 completes the exit
    // FAULT | anomalous pattern seen; wait for both beams clear
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IN1   = 3'd1,
        IN2   = 3'd2,
        IN3   = 3'd3,
        OUT1  = 3'd4,
        OUT2  = 3'd5,
        OUT3  = 3'd6,
        FAULT = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       car_in_q, car_in_d;
    logic       car_out_q, car_out_d;
    logic [1:0] ab;

    assign ab = {sensor_a, sensor_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            car_in_q  <= 1'b0;
            car_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            car_in_q  <= car_in_d;
            car_out_q <= car_out_d;
        end
    end

    // Pulses are decided here but only appear after the output flops load them.
    always_comb begin
        state_d   = state_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = IN1;
                    2'b01:   state_d = OUT1;
                    2'b11:   state_d = FAULT;
                    default: state_d = IDLE;
                endcase
            end
            IN1: begin
                case (ab)
                    2'b11:   state_d = IN2;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = FAULT;
                    default: state_d = IN1;
                endcase
            end
            IN2: begin
                case (ab)
                    2'b01:   state_d = IN3;
                    2'b10:   state_d = IN1;
                    2'b00:   state_d = FAULT;
                    default: state_d = IN2;
                endcase
            end
            IN3: begin
                case (ab)
                    2'b00: begin
                        state_d  = IDLE;
                        car_in_d = 1'b1;
                    end
                    2'b11:   state_d = IN2;
                    2'b10:   state_d = FAULT;
                    default: state_d = IN3;
                endcase
            end
            OUT1: begin
                case (ab)
                    2'b11:   state_d = OUT2;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = FAULT;
                    default: state_d = OUT1;
                endcase
            end
            OUT2: begin
                case (ab)
                    2'b10:   state_d = OUT3;
                    2'b01:   state_d = OUT1;
                    2'b00:   state_d = FAULT;
                    default: state_d = OUT2;
                endcase
            end
            OUT3: begin
                case (ab)
                    2'b00: begin
                        state_d   = IDLE;
                        car_out_d = 1'b1;
                    end
                    2'b11:   state_d = OUT2;
                    2'b01:   state_d = FAULT;
                    default: state_d = OUT3;
                endcase
            end
            FAULT: begin
                if (ab == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign carIn  = car_in_q;
    assign carOut = car_out_q;

endmodule

// File: tb/tb_fsm_autos.sv
// Bench for fsm_autos: directed passage scenarios plus biased random sensor
// traffic, checked against a sequence-position model of a car passage.
module tb_fsm_autos;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic carIn, carOut;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a passage is a walk along a 4-step beam sequence; dir 0=idle,
    // 1=entering, 2=leaving, 3=fault. pos is the index into that sequence.
    int m_dir = 0;
    int m_pos = 0;

    fsm_autos dut (
        .clk      (clk),
        .reset    (reset),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .carIn    (carIn),
        .carOut   (carOut)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] pat(input int dir, input int pos);
        logic [1:0] r;
        if (dir == 1) begin
            case (pos)
                0: r = 2'b00; 1: r = 2'b10; 2: r = 2'b11; default: r = 2'b01;
            endcase
        end else begin
            case (pos)
                0: r = 2'b00; 1: r = 2'b01; 2: r = 2'b11; default: r = 2'b10;
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input logic [1:0] ab, input logic rst,
                              output logic e_in, output logic e_out);
        e_in = 1'b0;
        e_out = 1'b0;
        if (rst) begin
            m_dir = 0; m_pos = 0;
        end else if (m_dir == 3) begin
            if (ab == 2'b00) begin m_dir = 0; m_pos = 0; end
        end else if (m_dir == 0) begin
            if (ab == 2'b10) begin m_dir = 1; m_pos = 1; end
            else if (ab == 2'b01) begin m_dir = 2; m_pos = 1; end
            else if (ab == 2'b11) m_dir = 3;
        end else begin
            if (ab == pat(m_dir, m_pos)) begin
                // holding the current pattern
            end else if (ab == pat(m_dir, (m_pos + 1) % 4)) begin
                m_pos = (m_pos + 1) % 4;
                if (m_pos == 0) begin
                    if (m_dir == 1) e_in = 1'b1; else e_out = 1'b1;
                    m_dir = 0;
                end
            end else if (ab == pat(m_dir, (m_pos + 3) % 4)) begin
                m_pos = m_pos - 1;
                if (m_pos == 0) m_dir = 0;
            end else begin
                m_dir = 3; m_pos = 0;
            end
        end
    endtask

    // Drives one sample period and returns what the DUT shows after the edge.
    task automatic step(input logic [1:0] ab, input logic rst,
                        output logic g_in, output logic g_out,
                        output logic e_in, output logic e_out);
        @(negedge clk);
        {sensor_a, sensor_b} = ab;
        reset = rst;
        model_step(ab, rst, e_in, e_out);
        @(posedge clk);
        #1;
        g_in = carIn;
        g_out = carOut;
        cyc++;
    endtask

    task automatic test_reset();
        logic gi, go, ei, eo;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b1, gi, go, ei, eo);
            n_checks++;
            if (gi !== 1'b0 || go !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d carIn=%b carOut=%b expected 0 0", cyc, gi, go);
            end
        end
        step(2'b00, 1'b0, gi, go, ei, eo);
        n_checks++;
        if (gi !== 1'b0 || go !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d carIn=%b carOut=%b expected 0 0", cyc, gi, go);
        end
    endtask

    task automatic test_entry();
        logic [1:0] p[6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
        logic gi, go, ei, eo;
        int cnt_in = 0, cnt_out = 0;
        for (int i = 0; i < 6; i++) begin
            step(p[i], 1'b0, gi, go, ei, eo);
            cnt_in += int'(gi); cnt_out += int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL entry cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
            if (i == 3) begin
                n_checks++;
                if (gi !== 1'b1) begin
                    n_fail++;
                    $display("FAIL entry_pulse_timing carIn=%b expected 1", gi);
                end
            end
        end
        n_checks++;
        if (cnt_in != 1 || cnt_out != 0) begin
            n_fail++;
            $display("FAIL entry_count carIn_pulses=%0d carOut_pulses=%0d expected 1 0", cnt_in, cnt_out);
        end
    endtask

    task automatic test_exit();
        logic [1:0] p[6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        logic gi, go, ei, eo;
        int cnt_in = 0, cnt_out = 0;
        for (int i = 0; i < 6; i++) begin
            step(p[i], 1'b0, gi, go, ei, eo);
            cnt_in += int'(gi); cnt_out += int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL exit cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
            if (i == 3) begin
                n_checks++;
                if (go !== 1'b1) begin
                    n_fail++;
                    $display("FAIL exit_pulse_timing carOut=%b expected 1", go);
                end
            end
        end
        n_checks++;
        if (cnt_in != 0 || cnt_out != 1) begin
            n_fail++;
            $display("FAIL exit_count carIn_pulses=%0d carOut_pulses=%0d expected 0 1", cnt_in, cnt_out);
        end
    endtask

    task automatic test_pedestrian();
        logic [1:0] p[6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic gi, go, ei, eo;
        int cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(p[i], 1'b0, gi, go, ei, eo);
            cnt += int'(gi) + int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL pedestrian cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL pedestrian_count pulses=%0d expected 0", cnt);
        end
    endtask

    task automatic test_abort();
        logic [1:0] p[14] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00,
                              2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        logic gi, go, ei, eo;
        int cnt_in = 0, cnt_out = 0;
        for (int i = 0; i < 14; i++) begin
            step(p[i], 1'b0, gi, go, ei, eo);
            cnt_in += int'(gi); cnt_out += int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL abort cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
        end
        n_checks++;
        if (cnt_in != 1 || cnt_out != 0) begin
            n_fail++;
            $display("FAIL abort_count carIn_pulses=%0d carOut_pulses=%0d expected 1 0", cnt_in, cnt_out);
        end
    endtask

    task automatic test_fault();
        logic [1:0] p[11] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00,
                              2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
        logic gi, go, ei, eo;
        int cnt_in = 0, cnt_out = 0;
        for (int i = 0; i < 11; i++) begin
            step(p[i], 1'b0, gi, go, ei, eo);
            cnt_in += int'(gi); cnt_out += int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL fault cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
        end
        n_checks++;
        if (cnt_in != 1 || cnt_out != 0) begin
            n_fail++;
            $display("FAIL fault_count carIn_pulses=%0d carOut_pulses=%0d expected 1 0", cnt_in, cnt_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] p[7] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        logic       r[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic gi, go, ei, eo;
        int cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(p[i], r[i], gi, go, ei, eo);
            cnt += int'(gi) + int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d carIn=%b carOut=%b expected %b %b", cyc, gi, go, ei, eo);
            end
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_count pulses=%0d expected 0", cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] ab;
        logic gi, go, ei, eo, rst;
        int exp_in = 0, exp_out = 0, got_in = 0, got_out = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 99);
            if (m_dir == 1 || m_dir == 2) begin
                if (sel < 45)      ab = pat(m_dir, (m_pos + 1) % 4);
                else if (sel < 70) ab = pat(m_dir, (m_pos + 3) % 4);
                else if (sel < 90) ab = pat(m_dir, m_pos);
                else               ab = 2'($urandom_range(0, 3));
            end else begin
                ab = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 199) == 0);
            step(ab, rst, gi, go, ei, eo);
            exp_in += int'(ei); exp_out += int'(eo);
            got_in += int'(gi); got_out += int'(go);
            n_checks++;
            if (gi !== ei || go !== eo) begin
                n_fail++;
                $display("FAIL random cyc=%0d ab=%b rst=%b carIn=%b carOut=%b expected %b %b",
                         cyc, ab, rst, gi, go, ei, eo);
            end
            n_checks++;
            if ((gi & go) !== 1'b0) begin
                n_fail++;
                $display("FAIL random_exclusive cyc=%0d carIn=%b carOut=%b expected not both 1", cyc, gi, go);
            end
        end
        n_checks++;
        if (got_in != exp_in || got_out != exp_out || exp_in + exp_out == 0) begin
            n_fail++;
            $display("FAIL random_totals carIn=%0d carOut=%0d expected %0d %0d (nonzero)",
                     got_in, got_out, exp_in, exp_out);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_pedestrian();
        test_abort();
        test_fault();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
